// File: rtl/ysyx_25020037_bypass_unit_pkg.sv
// Shared defaults for the IDU->EXU operand bypass scoreboard.
package ysyx_25020037_bypass_unit_pkg;
  localparam int BYPASS_DEPTH = 4;   // in-flight producer entries
  localparam int BYPASS_NSRC  = 2;   // source operand lookup ports
  localparam int GPR_AW       = 4;   // register index width (RV32E)
  localparam int GPR_DW       = 32;  // GPR data width
endpackage

// File: rtl/ysyx_25020037_bypass_lookup.sv
// Single-port priority matcher: finds the youngest valid entry writing i_rs
// and returns its value, or the register-file value when nothing matches.
module ysyx_25020037_bypass_lookup
  import ysyx_25020037_bypass_unit_pkg::*;
#(
  parameter int DEPTH     = BYPASS_DEPTH,
  parameter int AW        = GPR_AW,
  parameter int DW        = GPR_DW,
  parameter int LD_BYPASS = 0
) (
  input  logic [AW-1:0]             i_rs,
  input  logic [DW-1:0]             i_rf_data,
  input  logic [DEPTH-1:0]          i_vld,
  input  logic [DEPTH-1:0]          i_pend,
  input  logic [DEPTH-1:0]          i_oldest_pend,
  input  logic [DEPTH-1:0][AW-1:0]  i_rd,
  input  logic [DEPTH-1:0][DW-1:0]  i_data,
  input  logic                      i_ld_valid,
  input  logic [DW-1:0]             i_ld_data,
  output logic [DW-1:0]             o_data,
  output logic                      o_fwd,
  output logic                      o_wait
);

  // Scan oldest to youngest so the youngest match overrides any older one.
  always_comb begin
    o_data = i_rf_data;
    o_fwd  = 1'b0;
    o_wait = 1'b0;
    if (i_rs != '0) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (i_vld[k] && (i_rd[k] == i_rs)) begin
          o_fwd = 1'b1;
          if (!i_pend[k]) begin
            o_data = i_data[k];
            o_wait = 1'b0;
          end else if ((LD_BYPASS != 0) && i_ld_valid && i_oldest_pend[k]) begin
            // returning load data belongs to exactly this entry
            o_data = i_ld_data;
            o_wait = 1'b0;
          end else begin
            o_data = i_data[k];
            o_wait = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_25020037_bypass_unit.sv
// Operand-forwarding and load-use scoreboard between IDU and EXU.
// Keeps an age-ordered shift register of the last DEPTH issues (entry 0
// youngest); bubbles occupy slots so an entry's index equals its age.
module ysyx_25020037_bypass_unit
  import ysyx_25020037_bypass_unit_pkg::*;
#(
  parameter int DEPTH     = BYPASS_DEPTH,
  parameter int NSRC      = BYPASS_NSRC,
  parameter int AW        = GPR_AW,
  parameter int DW        = GPR_DW,
  parameter int LD_BYPASS = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         iss_valid,
  output logic                         iss_ready,
  input  logic                         ds_ready,
  input  logic                         flush,
  input  logic                         clear_all,
  input  logic [NSRC*AW-1:0]           iss_rs,
  input  logic [NSRC*DW-1:0]           iss_rf_data,
  input  logic                         iss_we,
  input  logic [AW-1:0]                iss_rd,
  input  logic                         iss_is_load,
  input  logic [DW-1:0]                iss_result,
  input  logic                         ld_done_valid,
  input  logic [DW-1:0]                ld_done_data,
  output logic [NSRC*DW-1:0]           src_data,
  output logic [NSRC-1:0]              src_fwd,
  output logic [NSRC-1:0]              src_wait,
  output logic [$clog2(DEPTH+1)-1:0]   pend_cnt,
  output logic                         drop_err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]          r_vld;
  logic [DEPTH-1:0]          r_pend;
  logic [DEPTH-1:0][AW-1:0]  r_rd;
  logic [DEPTH-1:0][DW-1:0]  r_data;
  logic                      r_drop_err;
  logic [CW-1:0]             r_pend_cnt;

  logic [DEPTH-1:0]          w_oldest_pend;
  logic                      w_fill;
  logic                      w_push;
  logic [DEPTH-1:0]          w_f_pend;
  logic [DEPTH-1:0][DW-1:0]  w_f_data;
  logic [DEPTH-1:0]          w_n_vld;
  logic [DEPTH-1:0]          w_n_pend;
  logic [DEPTH-1:0][AW-1:0]  w_n_rd;
  logic [DEPTH-1:0][DW-1:0]  w_n_data;
  logic [CW-1:0]             w_n_cnt;
  logic                      w_drop;

  // Oldest pending entry (highest index with pend set) as a one-hot vector;
  // loads return in program order so this is the one the next return fills.
  always_comb begin
    w_oldest_pend = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_pend[k]) begin
        w_oldest_pend    = '0;
        w_oldest_pend[k] = 1'b1;
      end
    end
  end

  assign w_fill    = ld_done_valid & (|r_pend);
  assign iss_ready = ds_ready & ~(|src_wait);
  assign w_push    = iss_valid & iss_ready & ~flush & ~clear_all;

  // Next entry state: fill in place first, then shift so a fill lands on the
  // entry's post-push slot; clear_all overrides both.
  always_comb begin
    w_f_pend = r_pend;
    w_f_data = r_data;
    if (w_fill) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_oldest_pend[k]) begin
          w_f_pend[k] = 1'b0;
          w_f_data[k] = ld_done_data;
        end
      end
    end
    w_n_vld  = r_vld;
    w_n_rd   = r_rd;
    w_n_pend = w_f_pend;
    w_n_data = w_f_data;
    if (w_push) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        w_n_vld[k]  = r_vld[k-1];
        w_n_rd[k]   = r_rd[k-1];
        w_n_pend[k] = w_f_pend[k-1];
        w_n_data[k] = w_f_data[k-1];
      end
      w_n_vld[0]  = iss_we && (iss_rd != '0);
      w_n_rd[0]   = iss_rd;
      w_n_pend[0] = iss_we && iss_is_load && (iss_rd != '0);
      w_n_data[0] = iss_is_load ? '0 : iss_result;
    end
    if (clear_all) begin
      w_n_vld  = '0;
      w_n_pend = '0;
    end
    // an unfilled pending load shifted off the end can never be delivered
    w_drop  = w_push & w_f_pend[DEPTH-1];
    w_n_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_n_cnt = w_n_cnt + CW'(w_n_pend[k]);
    end
  end

  // Entry array, pending count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld      <= '0;
      r_pend     <= '0;
      r_rd       <= '0;
      r_data     <= '0;
      r_drop_err <= 1'b0;
      r_pend_cnt <= '0;
    end else begin
      r_vld      <= w_n_vld;
      r_pend     <= w_n_pend;
      r_rd       <= w_n_rd;
      r_data     <= w_n_data;
      r_drop_err <= r_drop_err | w_drop;
      r_pend_cnt <= w_n_cnt;
    end
  end

  assign pend_cnt = r_pend_cnt;
  assign drop_err = r_drop_err;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    ysyx_25020037_bypass_lookup #(
      .DEPTH     (DEPTH),
      .AW        (AW),
      .DW        (DW),
      .LD_BYPASS (LD_BYPASS)
    ) u_lookup (
      .i_rs          (iss_rs[i*AW +: AW]),
      .i_rf_data     (iss_rf_data[i*DW +: DW]),
      .i_vld         (r_vld),
      .i_pend        (r_pend),
      .i_oldest_pend (w_oldest_pend),
      .i_rd          (r_rd),
      .i_data        (r_data),
      .i_ld_valid    (ld_done_valid),
      .i_ld_data     (ld_done_data),
      .o_data        (src_data[i*DW +: DW]),
      .o_fwd         (src_fwd[i]),
      .o_wait        (src_wait[i])
    );
  end

endmodule

// File: tb/tb_ysyx_25020037_bypass_unit.sv
// Directed bench: two instances share stimulus, A without and B with
// same-cycle load-data bypass.
module tb_ysyx_25020037_bypass_unit;
  localparam int AW = 4;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst, iss_valid, ds_ready, flush, clear_all;
  logic [7:0]  iss_rs;
  logic [63:0] iss_rf_data;
  logic        iss_we, iss_is_load, ld_done_valid;
  logic [3:0]  iss_rd;
  logic [31:0] iss_result, ld_done_data;

  logic        a_ready, b_ready, a_drop, b_drop;
  logic [63:0] a_data, b_data;
  logic [1:0]  a_fwd, b_fwd, a_wait, b_wait;
  logic [2:0]  a_cnt, b_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_25020037_bypass_unit #(.DEPTH(4), .NSRC(2), .AW(AW), .DW(DW), .LD_BYPASS(0)) u_dut_a (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(a_ready), .ds_ready(ds_ready),
    .flush(flush), .clear_all(clear_all), .iss_rs(iss_rs), .iss_rf_data(iss_rf_data),
    .iss_we(iss_we), .iss_rd(iss_rd), .iss_is_load(iss_is_load), .iss_result(iss_result),
    .ld_done_valid(ld_done_valid), .ld_done_data(ld_done_data), .src_data(a_data),
    .src_fwd(a_fwd), .src_wait(a_wait), .pend_cnt(a_cnt), .drop_err(a_drop));

  ysyx_25020037_bypass_unit #(.DEPTH(4), .NSRC(2), .AW(AW), .DW(DW), .LD_BYPASS(1)) u_dut_b (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_ready(b_ready), .ds_ready(ds_ready),
    .flush(flush), .clear_all(clear_all), .iss_rs(iss_rs), .iss_rf_data(iss_rf_data),
    .iss_we(iss_we), .iss_rd(iss_rd), .iss_is_load(iss_is_load), .iss_result(iss_result),
    .ld_done_valid(ld_done_valid), .ld_done_data(ld_done_data), .src_data(b_data),
    .src_fwd(b_fwd), .src_wait(b_wait), .pend_cnt(b_cnt), .drop_err(b_drop));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [3:0] rd, input logic ld, input logic [31:0] res);
    iss_valid = 1'b1; iss_we = we; iss_rd = rd; iss_is_load = ld; iss_result = res;
    tick();
    iss_valid = 1'b0; iss_we = 1'b0; iss_rd = '0; iss_is_load = 1'b0; iss_result = '0;
  endtask

  initial begin
    rst = 1'b1; iss_valid = 1'b0; ds_ready = 1'b1; flush = 1'b0; clear_all = 1'b0;
    iss_rs = '0; iss_rf_data = '0; iss_we = 1'b0; iss_rd = '0; iss_is_load = 1'b0;
    iss_result = '0; ld_done_valid = 1'b0; ld_done_data = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state and empty-table pass-through
    chk("rst_pend_cnt", a_cnt, 3'd0);
    chk("rst_drop_err", a_drop, 1'b0);
    iss_rs = {4'd6, 4'd5}; iss_rf_data = {32'h22, 32'h11}; #1;
    chk("empty_data", a_data, {32'h22, 32'h11});
    chk("empty_fwd", a_fwd, 2'b00);
    chk("empty_wait", a_wait, 2'b00);
    chk("empty_ready", a_ready, 1'b1);
    ds_ready = 1'b0; #1;
    chk("empty_ready_ds0", a_ready, 1'b0);
    ds_ready = 1'b1;

    // two ALU writes to x5: youngest wins
    iss_rs = '0;
    issue(1'b1, 4'd5, 1'b0, 32'hA);
    issue(1'b1, 4'd5, 1'b0, 32'hB);
    iss_rs = {4'd6, 4'd5}; #1;
    chk("youngest_data", a_data, {32'h22, 32'hB});
    chk("youngest_fwd", a_fwd, 2'b01);

    // load-use on x3
    iss_rs = '0;
    issue(1'b1, 4'd3, 1'b1, 32'hFFFF);
    iss_rs = {4'd0, 4'd3}; #1;
    chk("ld_wait", a_wait, 2'b01);
    chk("ld_ready", a_ready, 1'b0);
    chk("ld_pend_cnt", a_cnt, 3'd1);
    ld_done_valid = 1'b1; ld_done_data = 32'hDEAD; #1;
    chk("ld_same_cyc_nobyp_wait", a_wait, 2'b01);
    chk("ld_byp_data", b_data[31:0], 32'hDEAD);
    chk("ld_byp_wait", b_wait, 2'b00);
    chk("ld_byp_ready", b_ready, 1'b1);
    tick();
    ld_done_valid = 1'b0; ld_done_data = '0; #1;
    chk("ld_filled_data", a_data[31:0], 32'hDEAD);
    chk("ld_filled_wait", a_wait, 2'b00);
    chk("ld_filled_fwd", a_fwd, 2'b01);
    chk("ld_filled_cnt", a_cnt, 3'd0);

    // ordered fill of two loads; second fill coincides with a push
    iss_rs = '0;
    issue(1'b1, 4'd1, 1'b1, 32'h0);
    issue(1'b1, 4'd2, 1'b1, 32'h0);
    chk("two_ld_cnt", a_cnt, 3'd2);
    ld_done_valid = 1'b1; ld_done_data = 32'h100;
    tick();
    ld_done_data = 32'h200;
    issue(1'b1, 4'd9, 1'b0, 32'h99);
    ld_done_valid = 1'b0; ld_done_data = '0;
    iss_rs = {4'd2, 4'd1}; #1;
    chk("ordered_data", a_data, {32'h200, 32'h100});
    chk("ordered_wait", a_wait, 2'b00);
    chk("ordered_cnt", a_cnt, 3'd0);
    iss_rs = {4'd5, 4'd9}; #1;
    chk("push_fill_alu", a_data, {32'h22, 32'h99});
    chk("aged_out_fwd", a_fwd, 2'b01);

    // x0 never forwards
    iss_rs = '0;
    issue(1'b1, 4'd0, 1'b0, 32'h55);
    iss_rs = {4'd6, 4'd0}; #1;
    chk("x0_data", a_data[31:0], 32'h11);
    chk("x0_fwd", a_fwd, 2'b00);

    // pending load aged out by bubbles
    iss_rs = '0;
    issue(1'b1, 4'd7, 1'b1, 32'h0);
    issue(1'b0, 4'd0, 1'b0, 32'h0);
    issue(1'b0, 4'd0, 1'b0, 32'h0);
    issue(1'b0, 4'd0, 1'b0, 32'h0);
    chk("pre_drop_err", a_drop, 1'b0);
    chk("pre_drop_cnt", a_cnt, 3'd1);
    issue(1'b0, 4'd0, 1'b0, 32'h0);
    chk("drop_err", a_drop, 1'b1);
    chk("drop_cnt", a_cnt, 3'd0);
    tick(); tick();
    chk("drop_sticky", a_drop, 1'b1);

    // clear_all beats a simultaneous push
    issue(1'b1, 4'd4, 1'b1, 32'h0);
    issue(1'b1, 4'd5, 1'b0, 32'h55);
    issue(1'b1, 4'd6, 1'b0, 32'h66);
    issue(1'b1, 4'd8, 1'b1, 32'h0);
    chk("pre_clr_cnt", a_cnt, 3'd2);
    clear_all = 1'b1; iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 4'd10; iss_result = 32'hAA; #1;
    chk("clr_ready", a_ready, 1'b1);
    tick();
    clear_all = 1'b0; iss_valid = 1'b0; iss_we = 1'b0; iss_rd = '0; iss_result = '0;
    iss_rs = {4'd6, 4'd5}; #1;
    chk("clr_data", a_data, {32'h22, 32'h11});
    chk("clr_fwd", a_fwd, 2'b00);
    chk("clr_cnt", a_cnt, 3'd0);
    iss_rs = {4'd0, 4'd10}; #1;
    chk("clr_no_push", a_fwd, 2'b00);
    ld_done_valid = 1'b1; ld_done_data = 32'h1234;
    tick();
    ld_done_valid = 1'b0; ld_done_data = '0;
    iss_rs = {4'd8, 4'd4}; #1;
    chk("late_ld_data", a_data, {32'h22, 32'h11});
    chk("late_ld_cnt", a_cnt, 3'd0);
    chk("clr_keeps_drop", a_drop, 1'b1);

    // reset clears the sticky flag
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_clears_drop", a_drop, 1'b0);
    chk("rst_clears_drop_b", b_drop, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
